// File: rtl/led_chaser.sv
`timescale 1ns/1ps
// led_chaser: prescaled LED pattern sequencer with rotate-left/right, bounce and bar-fill modes.
// Define LED_CHASER_TRAIL_EN to also light the previous head in the one-hot modes.
module led_chaser #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned DIV_MAX = 49999999
) (
  input  logic             CLK1_50,
  input  logic             CLR_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [1:0]       SPEED,
  output logic [WIDTH-1:0] LEDR,
  output logic             STEP,
  output logic             WRAP
);

  localparam int unsigned DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DIV_W-1:0] PRE_TC    = DIV_W'(DIV_MAX);
  localparam logic [WIDTH-1:0] HEAD_INIT = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [DIV_W-1:0] pre_q, pre_d;
  logic [1:0]       tcnt_q, tcnt_d;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             base_tick_c;
  logic             step_c;
  logic [1:0]       thresh_c;

`ifdef LED_CHASER_TRAIL_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] led_q, led_d;
`endif

  // State register
  always_ff @(posedge CLK1_50 or negedge CLR_N) begin
    if (!CLR_N) begin
      pre_q  <= '0;
      tcnt_q <= '0;
      mode_q <= MODE_ROL;
      dir_q  <= DIR_UP;
      head_q <= HEAD_INIT;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
`ifdef LED_CHASER_TRAIL_EN
      prev_q <= '0;
      led_q  <= HEAD_INIT;
`endif
    end else begin
      pre_q  <= pre_d;
      tcnt_q <= tcnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      head_q <= head_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
`ifdef LED_CHASER_TRAIL_EN
      prev_q <= prev_d;
      led_q  <= led_d;
`endif
    end
  end

  // Prescaler and speed divider; >= lets a lowered threshold fire at the next base tick
  always_comb begin
    pre_d       = pre_q;
    tcnt_d      = tcnt_q;
    base_tick_c = EN && (pre_q == PRE_TC);
    thresh_c    = 2'd3 - SPEED;
    step_c      = base_tick_c && (tcnt_q >= thresh_c);
    if (EN) begin
      pre_d = base_tick_c ? '0 : pre_q + DIV_W'(1);
    end
    if (step_c) begin
      tcnt_d = '0;
    end else if (base_tick_c) begin
      tcnt_d = tcnt_q + 2'd1;
    end
  end

  // Pattern advance, mode capture and status pulses
  always_comb begin
    head_d = head_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = step_c;
    wrap_d = 1'b0;
`ifdef LED_CHASER_TRAIL_EN
    prev_d = prev_q;
`endif
    if (step_c) begin
      if (MODE != mode_q) begin
        mode_d = mode_e'(MODE);
        head_d = HEAD_INIT;
        dir_d  = DIR_UP;
`ifdef LED_CHASER_TRAIL_EN
        prev_d = '0;
`endif
      end else if (head_q == '0) begin
        head_d = HEAD_INIT;
`ifdef LED_CHASER_TRAIL_EN
        prev_d = '0;
`endif
      end else begin
`ifdef LED_CHASER_TRAIL_EN
        prev_d = (mode_q == MODE_BAR) ? '0 : head_q;
`endif
        case (mode_q)
          MODE_ROL: begin
            head_d = {head_q[WIDTH-2:0], head_q[WIDTH-1]};
            wrap_d = head_q[WIDTH-1];
          end
          MODE_ROR: begin
            head_d = {head_q[0], head_q[WIDTH-1:1]};
            wrap_d = head_q[0];
          end
          MODE_BOUNCE: begin
            // End bits are visited once: direction flips on arrival, not on departure
            if (dir_q == DIR_UP) begin
              if (head_q[WIDTH-1]) begin
                head_d = head_q >> 1;
                dir_d  = DIR_DOWN;
              end else begin
                head_d = head_q << 1;
                if (head_q[WIDTH-2]) begin
                  dir_d  = DIR_DOWN;
                  wrap_d = 1'b1;
                end
              end
            end else begin
              if (head_q[0]) begin
                head_d = head_q << 1;
                dir_d  = DIR_UP;
              end else begin
                head_d = head_q >> 1;
                if (head_q[1]) begin
                  dir_d  = DIR_UP;
                  wrap_d = 1'b1;
                end
              end
            end
          end
          MODE_BAR: begin
            if (&head_q) begin
              head_d = HEAD_INIT;
              wrap_d = 1'b1;
            end else begin
              head_d = (head_q << 1) | HEAD_INIT;
            end
          end
          default: begin
            head_d = HEAD_INIT;
          end
        endcase
      end
    end
`ifdef LED_CHASER_TRAIL_EN
    led_d = (mode_d == MODE_BAR) ? head_d : (head_d | prev_d);
`endif
  end

`ifdef LED_CHASER_TRAIL_EN
  assign LEDR = led_q;
`else
  assign LEDR = head_q;
`endif
  assign STEP = step_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_led_chaser.sv
`timescale 1ns/1ps
// tb_led_chaser: scoreboard bench for led_chaser at WIDTH=4, DIV_MAX=3.
module tb_led_chaser;

`ifdef LED_CHASER_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  logic       clk;
  logic       CLR_N;
  logic       EN;
  logic [1:0] MODE;
  logic [1:0] SPEED;
  logic [3:0] LEDR;
  logic       STEP;
  logic       WRAP;

  typedef struct {
    logic [3:0] led;
    logic       wrap;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_step = 0;

  led_chaser #(.WIDTH(4), .DIV_MAX(3)) dut (
    .CLK1_50(clk),
    .CLR_N  (CLR_N),
    .EN     (EN),
    .MODE   (MODE),
    .SPEED  (SPEED),
    .LEDR   (LEDR),
    .STEP   (STEP),
    .WRAP   (WRAP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] plain, input logic [3:0] trail, input logic wrap, input int gap);
    exp_t e;
    e.led  = TRAIL ? trail : plain;
    e.wrap = wrap;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL step_timeout: %0d expected steps never arrived", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input logic en, input logic [1:0] mode, input logic [1:0] speed);
    @(posedge clk);
    #2;
    CLR_N = 1'b0;
    EN    = en;
    MODE  = mode;
    SPEED = speed;
    #1;
    check("reset_ledr", 32'(LEDR), 32'h1);
    check("reset_step", 32'(STEP), 32'h0);
    check("reset_wrap", 32'(WRAP), 32'h0);
    repeat (2) @(posedge clk);
    #2 CLR_N = 1'b1;
  endtask

  // Monitor: pops one expectation per STEP pulse and checks pattern, WRAP and step spacing
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!CLR_N) begin
      last_step = cyc;
    end else begin
      check("wrap_without_step", 32'(WRAP & ~STEP), 32'h0);
      if (STEP) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_step: LEDR=%b WRAP=%b, expected no step", LEDR, WRAP);
        end else begin
          e = sb.pop_front();
          check("step_ledr", 32'(LEDR), 32'(e.led));
          check("step_wrap", 32'(WRAP), 32'(e.wrap));
          if (e.gap != 0) check("step_gap", 32'(cyc - last_step), 32'(e.gap));
        end
        last_step = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR_N = 1'b0;
    EN    = 1'b0;
    MODE  = 2'd0;
    SPEED = 2'd3;

    // Rotate-left at full speed
    do_reset(1'b1, 2'd0, 2'd3);
    push(4'b0010, 4'b0011, 1'b0, 5);
    push(4'b0100, 4'b0110, 1'b0, 4);
    push(4'b1000, 4'b1100, 1'b0, 4);
    push(4'b0001, 4'b1001, 1'b1, 4);
    push(4'b0010, 4'b0011, 1'b0, 4);
    wait_empty(100);

    // Bounce: first step is the mode capture
    do_reset(1'b1, 2'd2, 2'd3);
    push(4'b0001, 4'b0001, 1'b0, 5);
    push(4'b0010, 4'b0011, 1'b0, 4);
    push(4'b0100, 4'b0110, 1'b0, 4);
    push(4'b1000, 4'b1100, 1'b1, 4);
    push(4'b0100, 4'b1100, 1'b0, 4);
    push(4'b0010, 4'b0110, 1'b0, 4);
    push(4'b0001, 4'b0011, 1'b1, 4);
    push(4'b0010, 4'b0011, 1'b0, 4);
    wait_empty(100);

    // Bar-fill
    do_reset(1'b1, 2'd3, 2'd3);
    push(4'b0001, 4'b0001, 1'b0, 5);
    push(4'b0011, 4'b0011, 1'b0, 4);
    push(4'b0111, 4'b0111, 1'b0, 4);
    push(4'b1111, 4'b1111, 1'b0, 4);
    push(4'b0001, 4'b0001, 1'b1, 4);
    wait_empty(100);

    // Slowest speed, then raise speed when tcnt has reached 2
    do_reset(1'b1, 2'd0, 2'd0);
    push(4'b0010, 4'b0011, 1'b0, 17);
    push(4'b0100, 4'b0110, 1'b0, 16);
    wait_empty(100);
    push(4'b1000, 4'b1100, 1'b0, 12);
    push(4'b0001, 4'b1001, 1'b1, 4);
    push(4'b0010, 4'b0011, 1'b0, 4);
    repeat (8) @(posedge clk);
    #2 SPEED = 2'd3;
    wait_empty(100);

    // Pause: everything holds, then resume from the held prescaler count
    #2 EN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pause_ledr", 32'(LEDR), TRAIL ? 32'h3 : 32'h2);
      check("pause_step", 32'(STEP), 32'h0);
    end
    push(4'b0100, 4'b0110, 1'b0, 24);
    @(posedge clk);
    #2 EN = 1'b1;
    wait_empty(100);

    // Asynchronous reset between edges
    #3 CLR_N = 1'b0;
    #1;
    check("async_reset_ledr", 32'(LEDR), 32'h1);
    check("async_reset_step", 32'(STEP), 32'h0);
    check("async_reset_wrap", 32'(WRAP), 32'h0);

    // Mode change rotate-left -> rotate-right while head is at bit 2
    do_reset(1'b1, 2'd0, 2'd3);
    push(4'b0010, 4'b0011, 1'b0, 5);
    push(4'b0100, 4'b0110, 1'b0, 4);
    wait_empty(100);
    push(4'b0001, 4'b0001, 1'b0, 4);
    push(4'b1000, 4'b1001, 1'b1, 4);
    push(4'b0100, 4'b1100, 1'b0, 4);
    #2 MODE = 2'd1;
    wait_empty(100);

    @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
